fetch_buffer: RTL and testbench
===============================

// Module: fetch_buffer
// PURPOSE
//  In-order instruction buffer between the memory read-response path and decode.
//  - Captures fetched words, tags each with its PC, presents them to decode over valid/ready.
//  - Throttles the fetch unit with a credit-based stall so the buffer never overflows.
//  - On flush: empties the buffer, discards in-flight responses, redirects the PC.
// PARAMETERS
//  ADDR_WIDTH  32  PC / fetch address width
//  WORD_SIZE   4   instruction word size in bytes; also the PC increment
//  DEPTH       8   buffer entries; power of two, >= 2
//  RESET_PC    0   PC tagged on the first word after reset
// PORTS
//  clk         in   1                 clock
//  reset       in   1                 synchronous, active-high
//  req_issue   in   1                 fetch unit issued one memory read this cycle
//  fetch_stall out  1                 fetch unit must not issue while high
//  fill_valid  in   1                 memory read data ready this cycle (in-order response)
//  fill_data   in   WORD_SIZE*8       memory read data
//  flush       in   1                 discard buffer and in-flight reads; redirect
//  flush_pc    in   ADDR_WIDTH        PC of the first word fetched after flush
//  dec_valid   out  1                 head entry valid
//  dec_ready   in   1                 decode accepts head entry
//  dec_instr   out  WORD_SIZE*8       head instruction word
//  dec_pc      out  ADDR_WIDTH        head PC
//  occupancy   out  $clog2(DEPTH)+1   entries currently held
// BEHAVIOUR
//  - Reset: buffer empty. occupancy=0, dec_valid=0, fetch_stall=0. outstanding=0, drop_cnt=0.
//    next_pc=RESET_PC. dec_instr/dec_pc are don't-care while dec_valid=0.
//  - Counters (width $clog2(DEPTH)+2):
//    - outstanding += req_issue, -= fill_valid (net change when both occur).
//    - live = outstanding - drop_cnt.
//  - fetch_stall = (occupancy + live >= DEPTH). Combinational from registered state only.
//  - Fill acceptance: fill_valid && drop_cnt==0 && !flush.
//    - Writes {next_pc, fill_data} at the tail; next_pc += WORD_SIZE, wrapping mod 2^ADDR_WIDTH.
//    - Dropped fills (drop_cnt>0 or flush high) decrement drop_cnt (drop_cnt only, when >0)
//      and leave next_pc unchanged.
//  - Pop: dec_valid && dec_ready advances the head.
//    - Push and pop in the same cycle keep occupancy unchanged, including when full.
//  - Flush has priority over every other event in its cycle:
//    - Buffer empties next cycle; no pop is counted.
//    - next_pc <= flush_pc.
//    - drop_cnt <= outstanding + req_issue - fill_valid, so reads issued in the flush cycle
//      are also discarded.
//  - Overflow is impossible when the fetch unit honours fetch_stall.
//    - Simulation assertions fire on req_issue && fetch_stall,
//      and on fill_valid with outstanding==0.
//  - Latency (macro off): accepted fill appears on dec_* the next cycle. Head is held stable
//    while dec_valid && !dec_ready.
//  - Reset mid-operation: all state returns to reset values in one cycle; in-flight responses
//    arriving after reset are the memory side's responsibility (reset both together).
// CONFIGURATION
//  - FETCH_BUF_BYPASS_EN defined: when the buffer is empty and a fill is accepted, the fill
//    drives dec_* combinationally in the same cycle (dec_pc=next_pc).
//    - dec_ready high: the word is consumed and is not written.
//    - dec_ready low: the word is written as normal.
//    - flush still suppresses bypass.
//  - FETCH_BUF_BYPASS_EN undefined: no fill-to-decode combinational path; latency is 1 cycle.
// STRUCTURE
//  - fetch_pkg (shared):
//    - typedef fetch_entry_t {logic [ADDR_WIDTH-1:0] pc; logic [WORD_SIZE*8-1:0] instr;}
//    - PC increment constant.
//  - Sub-module fetch_buf_ram: DEPTH x fetch_entry_t register array with one write port and
//    an asynchronous read at the head pointer.
//  - Top level holds head/tail pointers (wrap at DEPTH), occupancy, the outstanding/drop
//    counters, next_pc and the stall/bypass logic.
// TESTING
//  - Reset, 3 issues then 3 fills 0xA,0xB,0xC, dec_ready=1 -> dec_pc 0,4,8 with matching
//    instr; occupancy returns to 0.
//  - DEPTH=8, dec_ready=0, issue until stall -> fetch_stall high after 8 issues;
//    pop one -> stall drops next cycle.
//  - 4 reads in flight, flush with flush_pc=0x100 -> next 4 fills dropped, drop_cnt=0;
//    next accepted fill tagged 0x100.
//  - Full buffer, simultaneous fill and pop -> occupancy stays 8; entry order preserved
//    across pointer wrap.
//  - Flush in the same cycle as fill_valid and req_issue (2 outstanding) -> fill dropped,
//    drop_cnt=2, buffer empty.
//  - FETCH_BUF_BYPASS_EN, empty buffer, fill with dec_ready=1 -> dec_valid in the same cycle,
//    occupancy stays 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared entry type and PC step for the fetch buffer
package fetch_pkg;
  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_WORD_SIZE = 4;
  localparam logic [FETCH_ADDR_W-1:0] PC_INC = FETCH_ADDR_W'(FETCH_WORD_SIZE);
  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]      pc;
    logic [FETCH_WORD_SIZE*8-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buf_ram.sv
// fetch_buf_ram: entry storage, one write port, asynchronous read at the head
module fetch_buf_ram
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  fetch_entry_t             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output fetch_entry_t             rdata
);
  fetch_entry_t mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: in-order PC-tagged instruction buffer with credit-based fetch stall.
// Define FETCH_BUF_BYPASS_EN for a same-cycle fill-to-decode path when empty.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int                     ADDR_WIDTH = FETCH_ADDR_W,
  parameter int                     WORD_SIZE  = FETCH_WORD_SIZE,
  parameter int                     DEPTH      = 8,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_issue,
  output logic                       fetch_stall,
  input  logic                       fill_valid,
  input  logic [WORD_SIZE*8-1:0]     fill_data,
  input  logic                       flush,
  input  logic [ADDR_WIDTH-1:0]      flush_pc,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [WORD_SIZE*8-1:0]     dec_instr,
  output logic [ADDR_WIDTH-1:0]      dec_pc,
  output logic [$clog2(DEPTH):0]     occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 2;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0] occ_q, occ_d;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, live;
  logic [ADDR_WIDTH-1:0] npc_q, npc_d;
  logic empty, accept, byp, push, pop;
  fetch_entry_t head_e;
  fetch_buf_ram #(.DEPTH(DEPTH)) u_ram (
    .clk  (clk),
    .we   (push),
    .waddr(tail_q),
    .wdata('{pc: npc_q, instr: fill_data}),
    .raddr(head_q),
    .rdata(head_e)
  );
  always_comb begin
    empty = occ_q == '0;
    live = out_q - drop_q;
    fetch_stall = CW'(occ_q) + live >= CW'(DEPTH);
    accept = fill_valid && drop_q == '0 && !flush;
`ifdef FETCH_BUF_BYPASS_EN
    byp = empty && accept;
`else
    byp = 1'b0;
`endif
    dec_valid = !empty || byp;
    dec_pc = byp ? npc_q : head_e.pc;
    dec_instr = byp ? fill_data : head_e.instr;
    pop = !empty && dec_ready && !flush;
    push = accept && !(byp && dec_ready);
    occ_d = flush ? '0 : occ_q + (PW+1)'(push) - (PW+1)'(pop);
    head_d = flush ? '0 : head_q + PW'(pop);
    tail_d = flush ? '0 : tail_q + PW'(push);
    out_d = out_q + CW'(req_issue) - CW'(fill_valid);
    // reads issued in the flush cycle are folded into the discard count
    drop_d = flush ? out_d : (fill_valid && drop_q != '0) ? drop_q - CW'(1) : drop_q;
    npc_d = flush ? flush_pc : accept ? npc_q + PC_INC : npc_q;
    occupancy = occ_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      out_q  <= '0;
      drop_q <= '0;
      npc_q  <= RESET_PC;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      out_q  <= out_d;
      drop_q <= drop_d;
      npc_q  <= npc_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(req_issue && fetch_stall)) else $error("fetch issued while stalled");
      assert (!(fill_valid && out_q == '0)) else $error("fill with no read outstanding");
    end
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: vector table, corner sequences and randomized run against a queue model
module tb_fetch_buffer;
  logic clk = 1'b0, reset = 1'b0;
  logic req_issue = 1'b0, fill_valid = 1'b0, flush = 1'b0, dec_ready = 1'b0;
  logic [31:0] fill_data = '0, flush_pc = '0;
  logic fetch_stall, dec_valid;
  logic [31:0] dec_instr, dec_pc;
  logic [3:0] occupancy;
  int total = 0, bad = 0;

  fetch_buffer dut (
    .clk(clk), .reset(reset), .req_issue(req_issue), .fetch_stall(fetch_stall),
    .fill_valid(fill_valid), .fill_data(fill_data), .flush(flush), .flush_pc(flush_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t q[$];
  int mout, mdrop;
  logic [31:0] mpc;

  function automatic bit mstall();
    return q.size() + mout - mdrop >= 8;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ri, input logic fv, input logic [31:0] fd,
                       input logic fl, input logic [31:0] fpc, input logic dr);
    @(negedge clk);
    req_issue = ri; fill_valid = fv; fill_data = fd; flush = fl; flush_pc = fpc; dec_ready = dr;
    #1;
  endtask

  task automatic tick();
    bit empty, accept, byp, ev;
    ent_t head;
    empty = q.size() == 0;
    accept = fill_valid && mdrop == 0 && !flush;
`ifdef FETCH_BUF_BYPASS_EN
    byp = empty && accept;
`else
    byp = 0;
`endif
    ev = !empty || byp;
    head = empty ? '{pc: mpc, instr: fill_data} : q[0];
    chk("m_valid", 64'(dec_valid), 64'(ev));
    if (ev) begin
      chk("m_pc", 64'(dec_pc), 64'(head.pc));
      chk("m_instr", 64'(dec_instr), 64'(head.instr));
    end
    chk("m_occ", 64'(occupancy), 64'(q.size()));
    chk("m_stall", 64'(fetch_stall), 64'(mstall()));
    @(posedge clk);
    if (flush) begin
      q.delete();
      mout = mout + int'(req_issue) - int'(fill_valid);
      mdrop = mout;
      mpc = flush_pc;
    end else begin
      if (!empty && dec_ready) void'(q.pop_front());
      if (accept) begin
        if (!(byp && dec_ready)) q.push_back('{pc: mpc, instr: fill_data});
        mpc = mpc + 32'd4;
      end else if (fill_valid && mdrop > 0) mdrop--;
      mout = mout + int'(req_issue) - int'(fill_valid);
    end
  endtask

  task automatic step(input logic ri, input logic fv, input logic [31:0] fd,
                      input logic fl, input logic [31:0] fpc, input logic dr);
    drive(ri, fv, fd, fl, fpc, dr);
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_issue = 0; fill_valid = 0; flush = 0; dec_ready = 0;
    @(posedge clk);
    q.delete(); mout = 0; mdrop = 0; mpc = 32'd0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic ri, fv; logic [31:0] fd; logic dr;
    logic ev; logic [31:0] epc, einstr; logic [3:0] eocc; logic estall;
  } vec_t;
  vec_t vt[8];

  initial begin
    vt[0] = '{1, 0, 32'h0, 1, 0, 32'h0, 32'h0, 4'd0, 0};
    vt[1] = '{1, 0, 32'h0, 1, 0, 32'h0, 32'h0, 4'd0, 0};
    vt[2] = '{1, 0, 32'h0, 1, 0, 32'h0, 32'h0, 4'd0, 0};
    vt[3] = '{0, 1, 32'hA, 1, 0, 32'h0, 32'h0, 4'd0, 0};
    vt[4] = '{0, 1, 32'hB, 1, 1, 32'h0, 32'hA, 4'd1, 0};
    vt[5] = '{0, 1, 32'hC, 1, 1, 32'h4, 32'hB, 4'd1, 0};
    vt[6] = '{0, 0, 32'h0, 1, 1, 32'h8, 32'hC, 4'd1, 0};
    vt[7] = '{0, 0, 32'h0, 1, 0, 32'h0, 32'h0, 4'd0, 0};

    do_reset();
    drive(0, 0, 0, 0, 0, 0);
    chk("rst_valid", 64'(dec_valid), 0);
    chk("rst_occ", 64'(occupancy), 0);
    chk("rst_stall", 64'(fetch_stall), 0);
    tick();

`ifndef FETCH_BUF_BYPASS_EN
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].ri, vt[i].fv, vt[i].fd, 0, 0, vt[i].dr);
      chk("v_valid", 64'(dec_valid), 64'(vt[i].ev));
      if (vt[i].ev) begin
        chk("v_pc", 64'(dec_pc), 64'(vt[i].epc));
        chk("v_instr", 64'(dec_instr), 64'(vt[i].einstr));
      end
      chk("v_occ", 64'(occupancy), 64'(vt[i].eocc));
      chk("v_stall", 64'(fetch_stall), 64'(vt[i].estall));
      tick();
    end
`endif

    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      chk("pre_stall", 64'(fetch_stall), 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("stall_at_8", 64'(fetch_stall), 1);
    tick();
    for (int i = 0; i < 8; i++) step(0, 1, 32'h100 + i, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    chk("full_occ", 64'(occupancy), 8);
    chk("full_stall", 64'(fetch_stall), 1);
    chk("full_head", 64'(dec_pc), 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("pop_unstall", 64'(fetch_stall), 0);
    chk("pop_occ", 64'(occupancy), 7);
    tick();
    for (int k = 0; k < 6; k++) begin
      step(1, 0, 0, 0, 0, 0);
      drive(0, 1, 32'h200 + k, 0, 0, 1);
      chk("wrap_head", 64'(dec_pc), 64'(4 + 4 * k));
      tick();
      drive(0, 0, 0, 0, 0, 0);
      chk("wrap_occ", 64'(occupancy), 7);
      tick();
    end
    for (int j = 0; j < 7; j++) begin
      drive(0, 0, 0, 0, 0, 1);
      chk("drain_pc", 64'(dec_pc), 64'(28 + 4 * j));
      chk("drain_instr", 64'(dec_instr), j == 0 ? 64'h107 : 64'(32'h200 + j - 1));
      tick();
    end

    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h100, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 32'hDEAD, 0, 0, 1);
      chk("drop_valid", 64'(dec_valid), 0);
      tick();
    end
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'hD, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("redir_valid", 64'(dec_valid), 1);
    chk("redir_pc", 64'(dec_pc), 32'h100);
    chk("redir_instr", 64'(dec_instr), 32'hD);
    tick();

    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'hA, 0, 0, 0);
    drive(1, 1, 32'hEE, 1, 32'h200, 0);
    chk("pre_flush_occ", 64'(occupancy), 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("flush_occ", 64'(occupancy), 0);
    chk("flush_valid", 64'(dec_valid), 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 32'hBAD, 0, 0, 1);
      chk("coll_drop", 64'(dec_valid), 0);
      tick();
    end
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h5, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("coll_pc", 64'(dec_pc), 32'h200);
    chk("coll_instr", 64'(dec_instr), 32'h5);
    tick();

`ifdef FETCH_BUF_BYPASS_EN
    do_reset();
    step(1, 0, 0, 0, 0, 0);
    drive(0, 1, 32'h77, 0, 0, 1);
    chk("byp_valid", 64'(dec_valid), 1);
    chk("byp_pc", 64'(dec_pc), 0);
    chk("byp_instr", 64'(dec_instr), 32'h77);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("byp_occ", 64'(occupancy), 0);
    tick();
`endif

    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic ri, fv, fl, dr;
      if (n == 1500) do_reset();
      ri = !mstall() && ($urandom % 2 == 0);
      fv = mout > 0 && ($urandom % 3 != 0);
      fl = $urandom % 50 == 0;
      dr = $urandom % 4 != 0;
      step(ri, fv, $urandom, fl, $urandom, dr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
